ahb_wb_bridge: RTL

Single-master AHB-Lite slave to Wishbone classic master bridge. It sits between the Hazard3 single-port AHB-Lite master and the processorci Wishbone core port (core_cyc/stb/we/addr/data/ack) driven by the Controller. It sequences each AHB transfer into exactly one Wishbone cycle and stalls the AHB data phase until the Wishbone ack arrives.

---
 rtl/ahb_wb_pkg.sv | 30 +++
 rtl/ahb_wb_bridge_if.sv | 35 +++
 rtl/ahb_wb_timeout.sv | 28 ++
 rtl/ahb_wb_bridge.sv | 109 ++++++++++
 4 files changed

// File: rtl/ahb_wb_pkg.sv
// Shared AHB-Lite / Wishbone definitions for the ahb_wb_bridge: transfer and
// size encodings, bridge FSM states and byte-select decode.
package ahb_wb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_e;

  function automatic logic [3:0] sel_from_size(input logic [2:0] size,
                                               input logic [1:0] lsb);
    logic [3:0] sel;
    if (size == HSIZE_BYTE)      sel = 4'b0001 << lsb;
    else if (size == HSIZE_HALF) sel = lsb[1] ? 4'b1100 : 4'b0011;
    else                         sel = 4'b1111;
    return sel;
  endfunction

endpackage

// File: rtl/ahb_wb_bridge_if.sv
// AHB-Lite slave side and Wishbone classic master side of the bridge.
// slave = bridge view, master = view of whatever drives the AHB and answers on Wishbone.
interface ahb_wb_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic              hresp;
  logic              hexokay;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [3:0]        wb_sel;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack;

  modport slave (
    input  haddr, hwrite, htrans, hsize, hwdata, wb_dat_i, wb_ack,
    output hrdata, hready, hresp, hexokay,
           wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_dat_o
  );

  modport master (
    output haddr, hwrite, htrans, hsize, hwdata, wb_dat_i, wb_ack,
    input  hrdata, hready, hresp, hexokay,
           wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_dat_o
  );
endinterface

// File: rtl/ahb_wb_timeout.sv
// Wishbone ack watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYCLES-1.
module ahb_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (en_i && !expire_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite slave to Wishbone classic master: one Wishbone cycle per AHB transfer,
// data phase stalled until ack. Optional ack watchdog under AHB_WB_TIMEOUT_EN.
module ahb_wb_bridge
  import ahb_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
) (
  input logic           clk,
  input logic           rst_n,
  ahb_wb_bridge_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic              accept;
  logic              in_bus;
  logic              expire;
  logic              unused_bits;

  assign unused_bits = bus.htrans[0];

`ifdef AHB_WB_TIMEOUT_EN
  // Cleared whenever a fresh Wishbone cycle starts or the current one is acked.
  ahb_wb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    ((state_q != BUS) || bus.wb_ack),
    .en_i     (state_q == BUS),
    .expire_o (expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 1);
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.wb_cyc = 1'b0;
    case (state_q)
      BUS: begin
        bus.wb_cyc = 1'b1;
        bus.hready = bus.wb_ack;
      end
`ifdef AHB_WB_TIMEOUT_EN
      ERR1: begin
        bus.hready = 1'b0;
        bus.hresp  = 1'b1;
      end
      ERR2: bus.hresp = 1'b1;
`endif
      default: ;
    endcase

    accept = bus.hready && bus.htrans[1];

    case (state_q)
      IDLE: if (accept) state_d = BUS;
      BUS: begin
        if (bus.wb_ack) state_d = accept ? BUS : IDLE;
        else if (expire) state_d = ERR1;
      end
`ifdef AHB_WB_TIMEOUT_EN
      ERR1: state_d = ERR2;
      ERR2: state_d = accept ? BUS : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    we_d   = we_q;
    sel_d  = sel_q;
    if (accept) begin
      addr_d = bus.haddr;
      we_d   = bus.hwrite;
      sel_d  = sel_from_size(bus.hsize, bus.haddr[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
    end
  end

  assign in_bus       = (state_q == BUS);
  assign bus.wb_stb   = bus.wb_cyc;
  assign bus.wb_we    = in_bus && we_q;
  assign bus.wb_addr  = addr_q;
  assign bus.wb_sel   = sel_q;
  // hwdata is stable here because hready stays low until the ack.
  assign bus.wb_dat_o = (in_bus && we_q) ? bus.hwdata : 32'h0;
  assign bus.hrdata   = (in_bus && bus.wb_ack) ? bus.wb_dat_i : 32'h0;
  assign bus.hexokay  = 1'b0;
endmodule
